fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction word width in bits.
REQ-003 SHALL have parameter PC_RESET, default 0, PC value loaded on reset.
REQ-004 SHALL have parameter PC_STEP, default 1, PC increment per retired instruction.
REQ-005 SHALL have parameter CNT_W, default 16, retire-counter width.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port stall  input  1  holds the sequencer in FETCH without issuing a read.
REQ-009 SHALL have port mem_addr  output  PC_W  read address, always equal to pc.
REQ-010 SHALL have port mem_rd_en  output  1  one-cycle read request.
REQ-011 SHALL have port mem_rdata  input  INSTR_W  instruction word from memory.
REQ-012 SHALL have port mem_rvalid  input  1  mem_rdata is valid this cycle.
REQ-013 SHALL have port instr  output  INSTR_W  registered instruction to ALU.
REQ-014 SHALL have port instr_valid  output  1  instr is offered to ALU.
REQ-015 SHALL have port instr_ready  input  1  ALU accepts instr.
REQ-016 SHALL have port branch_en  input  1  redirect request, present only under FETCH_SEQ_BRANCH_EN.
REQ-017 SHALL have port branch_target  input  PC_W  redirect address, present only under FETCH_SEQ_BRANCH_EN.
REQ-018 SHALL have port pc  output  PC_W  current program counter.
REQ-019 SHALL have port state  output  2  current FSM code.
REQ-020 SHALL have port retire_cnt  output  CNT_W  count of accepted instructions.

Function
REQ-021 SHALL implement FSM states FETCH=0, WAIT=1, ISSUE=2; code 3 is illegal and SHALL return to FETCH on the next edge without changing pc.
REQ-022 FETCH: mem_rd_en=1 combinationally when !stall; on that edge go to WAIT; when stall=1, mem_rd_en=0 and remain in FETCH.
REQ-023 WAIT: mem_rd_en=0; on an edge with mem_rvalid=1, capture mem_rdata into instr, set instr_valid=1, and go to ISSUE; otherwise remain (unbounded wait).
REQ-024 ISSUE: instr_valid=1 and instr stable until the edge with instr_ready=1; on that edge instr_valid<=0, retire_cnt increments, pc updates, and the FSM goes to FETCH.
REQ-025 pc update on retire SHALL be pc+PC_STEP modulo 2^PC_W (wrap-around, no flag); retire_cnt SHALL wrap modulo 2^CNT_W.
REQ-026 instr SHALL hold its last captured value outside ISSUE and is never driven to high impedance.
REQ-027 mem_rvalid outside WAIT and instr_ready outside ISSUE SHALL be ignored.
REQ-028 stall SHALL affect only FETCH; asserting it in WAIT or ISSUE SHALL have no effect.
REQ-029 Minimum throughput SHALL be one instruction per 3 cycles (rvalid and ready both high on their first eligible edge).

Reset
REQ-030 While rst=0: state=FETCH, pc=PC_RESET, instr=0, instr_valid=0, retire_cnt=0, mem_rd_en=0, applied asynchronously.
REQ-031 A reset asserted mid-WAIT or mid-ISSUE SHALL discard the pending instruction; the first rising edge after release SHALL issue a read of PC_RESET when stall=0.

Configuration
REQ-032 With FETCH_SEQ_BRANCH_EN defined: branch_en=1 on the ISSUE retire edge SHALL load pc<=branch_target instead of pc+PC_STEP; branch_en is ignored on all other edges.
REQ-033 Without FETCH_SEQ_BRANCH_EN: branch ports SHALL be absent and pc SHALL only increment.

Structure
REQ-034 State codes and their 2-bit width SHALL reside in shared package fetch_seq_pkg.
REQ-035 The block SHALL be a single module; no sub-module is required.

Verification
REQ-036 Reset release, stall=0, mem_rvalid and instr_ready tied high, mem_rdata=32'hA5A5_0001 -> mem_addr sequence 0,1,2; instr_valid pulses every 3rd cycle; retire_cnt=3 after 9 cycles.
REQ-037 mem_rvalid delayed 4 cycles in WAIT -> state stays 1 for 4 cycles, mem_rd_en=0, instr captured on the rvalid edge only.
REQ-038 instr_ready held low 5 cycles in ISSUE -> instr and instr_valid stable for 5 cycles, pc unchanged at 0, retire on the 6th edge.
REQ-039 PC_W=4, pc=4'hF, retire -> pc=4'h0, no other side effect.
REQ-040 FETCH_SEQ_BRANCH_EN, branch_en=1, branch_target=16'h0040 on the retire edge -> next mem_addr=16'h0040; branch_en in WAIT -> ignored.
REQ-041 rst pulsed low during ISSUE -> instr_valid=0 immediately, pc=PC_RESET, retire_cnt=0, next read at PC_RESET.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state codes and width.
package fetch_seq_pkg;

  localparam int unsigned STATE_W = 2;

  // Code 3 is deliberately unused; the sequencer treats it as a return-to-FETCH.
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: FETCH -> WAIT -> ISSUE loop that reads an instruction at pc and hands it to the ALU.
// Optional macro FETCH_SEQ_BRANCH_EN adds branch_en/branch_target to redirect pc on the retire edge.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned PC_RESET = 0,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_rd_en,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
`ifdef FETCH_SEQ_BRANCH_EN
  input  logic               branch_en,
  input  logic [PC_W-1:0]    branch_target,
`endif
  output logic [PC_W-1:0]    pc,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retire_cnt
);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [INSTR_W-1:0] instr_q;
  logic               instr_valid_q;
  logic [CNT_W-1:0]   retire_cnt_q;

  // pc_d is only consumed on the ISSUE retire edge, so branch_en elsewhere has no effect.
  always_comb begin
    pc_d = pc_q + PC_W'(PC_STEP);
`ifdef FETCH_SEQ_BRANCH_EN
    if (branch_en) begin
      pc_d = branch_target;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= PC_W'(PC_RESET);
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!stall) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            instr_q       <= mem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            retire_cnt_q  <= retire_cnt_q + CNT_W'(1);
            pc_q          <= pc_d;
            state_q       <= ST_FETCH;
          end
        end
        default: begin
          state_q       <= ST_FETCH;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Read request is combinational on stall; gated by rst so it is low throughout reset.
  assign mem_rd_en   = rst && (state_q == ST_FETCH) && !stall;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign retire_cnt  = retire_cnt_q;
  assign state       = state_q;

endmodule
